// File: rtl/repsub_divider.sv
// repsub_divider: unsigned divider by repeated subtraction, one subtract per clock.
module repsub_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         dz
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t       r_state;
  logic [W-1:0] r_div;
  logic         w_ge;
  logic         w_zero;
  assign w_ge   = remainder >= r_div;
  assign w_zero = divisor == '0;
  assign busy   = r_state == SUB;
  assign done   = r_state == DONE;
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_div     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          remainder <= dividend;
          r_div     <= divisor;
          quotient  <= w_zero ? '1 : '0;
          dz        <= w_zero;
          r_state   <= w_zero ? DONE : SUB;
        end
        SUB: if (w_ge) begin
          remainder <= remainder - r_div;
          quotient  <= quotient + 1'b1;
        end else begin
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_repsub_divider.sv
// tb_repsub_divider: random and directed checks against an arithmetic reference model.
module tb_repsub_divider;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, dz;
  int          n_cmp = 0;
  int          n_err = 0;

  repsub_divider #(.W(16)) dut (
    .clk(clk), .clr(clr), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one division; optionally pulse a stray 50/3 start while busy.
  task automatic div(input logic [15:0] a, input logic [15:0] b, input bit inj);
    int          lat, nb;
    logic [15:0] eq, er;
    eq = (b == 0) ? 16'hFFFF : a / b;
    er = (b == 0) ? a : a % b;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = 0;
    nb  = 0;
    while (!done && lat < 70000) begin
      if (busy) nb++;
      if (inj && lat == 3) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd3;
      end else start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    check($sformatf("done_seen %0d/%0d", a, b), 36'(done), 36'd1);
    check($sformatf("latency %0d/%0d", a, b), 36'(lat), (b == 0) ? 36'd0 : 36'(int'(eq) + 1));
    check($sformatf("busy_cycles %0d/%0d", a, b), 36'(nb), (b == 0) ? 36'd0 : 36'(int'(eq) + 1));
    check($sformatf("quotient %0d/%0d", a, b), 36'(quotient), 36'(eq));
    check($sformatf("remainder %0d/%0d", a, b), 36'(remainder), 36'(er));
    check($sformatf("dz %0d/%0d", a, b), 36'(dz), 36'(b == 0));
    check($sformatf("busy_at_done %0d/%0d", a, b), 36'(busy), 36'd0);
    if (b != 0)
      check($sformatf("invariant %0d/%0d", a, b),
            {3'b0, 32'(quotient) * 32'(b) + 32'(remainder) == 32'(a), remainder < b}, 36'b11);
    tick();
    check($sformatf("done_pulse %0d/%0d", a, b), 36'(done), 36'd0);
    check($sformatf("hold %0d/%0d", a, b), {3'b0, busy, dz, quotient, remainder},
          {4'b0, b == 0, eq, er});
  endtask

  initial begin
    int n_done;
    logic [15:0] ra, rb;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_outputs", {3'b0, busy, done, dz, quotient, remainder}, 36'd0);
    end
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_outputs", {3'b0, busy, done, dz, quotient, remainder}, 36'd0);
    end
    div(16'd100, 16'd7, 1'b0);
    div(16'd5, 16'd9, 1'b0);
    div(16'd9, 16'd9, 1'b0);
    div(16'd0, 16'd0, 1'b0);
    div(16'd1234, 16'd0, 1'b0);
    div(16'd20, 16'd4, 1'b0);
    div(16'd65535, 16'd1, 1'b0);
    div(16'd65535, 16'd65535, 1'b0);
    div(16'd100, 16'd7, 1'b1);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clr   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_mid_sub", {3'b0, busy, done, dz, quotient, remainder}, 36'd0);
    clr = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("no_done_after_clr", 36'(n_done), 36'd0);
    div(16'd17, 16'd5, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = (i < 4) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(256, 65535));
      if (i < 4) ra = ra % 16'd200;
      div(ra, rb, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/repsub_divider.md
Name: repsub_divider

Overview:
- Sequential unsigned divider that works by repeated subtraction. It is the inverse of the team's repeated-addition multiplier datapath (load registers, adder, zero-detect, down-counter).
- It accepts a dividend/divisor pair on a start pulse and subtracts the divisor once per clock. It reports quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- It sits beside the multiplier as a standalone arithmetic unit under a simple start/done handshake.

Parameters:
- W, 16, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  W  unsigned dividend; sampled on the start edge.
- divisor  input  W  unsigned divisor; sampled on the start edge.
- quotient  output  W  registered result.
- remainder  output  W  registered result.
- busy  output  1  high while subtracting (SUB state).
- done  output  1  one-cycle pulse when results are valid.
- dz  output  1  divide-by-zero flag; valid with done and held until the next accepted start.

Behaviour:
- Clocking and reset: one clock (clk). clr is synchronous and active-high.
- Reset values, applied on any edge with clr=1 (including mid-operation):
  - state=IDLE
  - quotient=0, remainder=0
  - busy=0, done=0, dz=0
  - internal divisor register=0
  - Any operation in flight is abandoned and no done pulse is produced.
- States: IDLE, SUB, DONE. Encoding is free. All outputs are registered or Moore-decoded from state.
- IDLE:
  - start=0: hold all outputs.
  - start=1, divisor!=0:
    - remainder<=dividend, divisor register<=divisor, quotient<=0, dz<=0.
    - Go to SUB.
  - start=1, divisor==0:
    - quotient<=all ones, remainder<=dividend, dz<=1.
    - Go to DONE directly.
- SUB, one comparison per edge:
  - remainder>=divisor register: remainder<=remainder-divisor register; quotient<=quotient+1; stay in SUB.
  - otherwise: go to DONE with no register change.
  - Comparison is full W-bit unsigned. Subtraction never underflows because it is gated by the comparison.
  - quotient cannot wrap: the maximum is 2^W-1, reached only with divisor=1.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Output signals:
  - busy=1 only in SUB.
  - done=1 only in DONE.
- Latency, counting the start-sampling edge as edge 0:
  - divisor!=0: SUB occupies Q+1 edges (Q subtractions plus one failing compare). done is high in the cycle after edge Q+1. The next start can be sampled at edge Q+3 at the earliest.
  - divisor==0: done is high in the cycle after edge 0.
- Start in SUB or DONE is ignored, not queued. Operand inputs are don't-care except on the accepted start edge.
- Results and dz hold their values in IDLE until the next accepted start or clr.
- Simultaneous clr and start: clr wins and start is dropped.
- Invariant: dividend == quotient*divisor + remainder and remainder < divisor, checked with done=1 and dz=0.

Test Plan:
- Reset then idle: clr=1 for 2 cycles, then 5 idle cycles → every output 0 throughout; busy and done never assert.
- Normal division: dividend=100, divisor=7, start pulsed 1 cycle → busy for 15 cycles (14 subtractions plus 1 compare); done pulses once, 15 cycles after the start edge; quotient=14, remainder=2, dz=0; values hold afterwards.
- Dividend smaller than divisor: 5/9 → done 1 cycle after SUB entry (edge 1); quotient=0, remainder=5. Also 9/9 → quotient=1, remainder=0.
- Divide by zero: 0/0 and 1234/0 → done in the cycle after the start edge; busy never asserts; dz=1, quotient=16'hFFFF, remainder equals the dividend. A following 20/4 clears dz and gives quotient=5, remainder=0.
- Extremes: 65535/1 → quotient=65535, remainder=0, done after 65536 SUB edges. 65535/65535 → quotient=1, remainder=0.
- Protocol abuse:
  - Pulse start with 50/3 while a 100/7 operation is busy → ignored; result is 14 r 2.
  - Assert clr mid-SUB → next cycle state IDLE, all outputs 0, no done pulse.
  - After clr releases, a fresh 17/5 completes correctly: quotient=3, remainder=2.
  - Randomised operand pairs (divisor!=0) must satisfy the invariant.
